// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial slice-streaming add/subtract controller.
// Holds the FSM encoding and the slice width used by the controller and adder slice.
package serial_add_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_adder.sv
// 4-bit carry-select adder slice: low pair ripples from cin, high pair is
// precomputed for both carries and selected by the low-pair carry.
module serial_add_ctrl_adder
  import serial_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  always_comb begin
    lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;
    if (lo[2]) begin
      sum  = {hi1[1:0], lo[1:0]};
      cout = hi1[2];
    end else begin
      sum  = {hi0[1:0], lo[1:0]};
      cout = hi0[2];
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract that streams 4-bit slices, LSB first,
// through a single shared adder slice with a registered inter-slice carry.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned SLICES = WIDTH / SLICE_W;
  localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(SLICES - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic               cout_q;
  logic               ovf_q;

  logic               accept;
  logic               run_en;
  logic               last;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StRun;
      StRun:  if (last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    run_en    = (state_q == StRun);
    accept    = in_valid && in_ready;
    last      = run_en && (cnt_q == LastCnt);
  end

  assign sl_a = a_q[cnt_q*SLICE_W +: SLICE_W];
  assign sl_b = b_q[cnt_q*SLICE_W +: SLICE_W];

  serial_add_ctrl_adder u_adder (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  // Datapath: operand capture at accept, one slice written back per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub | cin;
      cnt_q   <= '0;
    end else if (run_en) begin
      res_q[cnt_q*SLICE_W +: SLICE_W] <= sl_sum;
      carry_q <= sl_cout;
      if (last) begin
        cout_q <= sl_cout;
        // Signed overflow: like-signed operands producing an opposite-signed result
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[SLICE_W-1] != a_q[WIDTH-1]);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sum      = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=16.
module tb_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int vectors;
  int miscompares;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one operation for a single accept edge and returns edges-to-out_valid.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                       input logic tsub, output int lat);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    vectors++;
    if (sum !== 16'h0000 || cout !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out got sum=%h cout=%b ovf=%b want 0000 0 0", sum, cout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int lat;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lat_ready got %b want 1", in_ready);
    end
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("FAIL latency got %0d want 4", lat);
    end
    vectors++;
    if (sum !== 16'h5555 || cout !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_result got %h/%b/%b want 5555/0/0", sum, cout, overflow);
    end
    release_result();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  task automatic test_arith();
    vec_t tbl[8];
    int   lat;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[5] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[7] = '{16'hA5C3, 16'h5A3C, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat);
      vectors++;
      if (lat != 4 || sum !== tbl[i].s || cout !== tbl[i].c || overflow !== tbl[i].o) begin
        miscompares++;
        $display("FAIL arith[%0d] got lat=%0d %h/%b/%b want lat=4 %h/%b/%b", i, lat, sum, cout,
                 overflow, tbl[i].s, tbl[i].c, tbl[i].o);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
    vectors++;
    if (lat != 4 || sum !== 16'h1000) begin
      miscompares++;
      $display("FAIL bp_setup got lat=%0d sum=%h want 4 1000", lat, sum);
    end
    for (int i = 0; i < 5; i++) begin
      a = ~a; b = b + 16'h1111; in_valid = ~in_valid; sub = ~sub;
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h1000 || cout !== 1'b0 ||
          overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b %h/%b/%b want 1 0 1000/0/0", i, out_valid,
                 in_ready, sum, cout, overflow);
      end
    end
    in_valid = 1'b0; sub = 1'b0;
    release_result();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h1000) begin
      miscompares++;
      $display("FAIL bp_release got r=%b v=%b sum=%h want 1 0 1000", in_ready, out_valid, sum);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_no_accept got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b0 ||
        overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst got v=%b r=%b %h/%b/%b want 0 1 0000/0/0", out_valid, in_ready,
               sum, cout, overflow);
    end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
    vectors++;
    if (lat != 4 || sum !== 16'h3333 || cout !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL post_rst got lat=%0d %h/%b/%b want 4 3333/0/0", lat, sum, cout, overflow);
    end
    release_result();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_latency();
    test_arith();
    test_backpressure();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
